ntt_ctrl: RTL

NTT_CTRL -- requirements
Module: ntt_ctrl

---
 rtl/ntt_pkg.sv | 23 ++
 rtl/ntt_ctrl_if.sv | 36 +++
 rtl/ntt_addr_gen.sv | 35 +++
 rtl/ntt_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and layer helpers for the NTT
// address/control sequencer.
package ntt_pkg;

    localparam int N             = 256;
    localparam int LOGN          = 8;
    localparam int KYBER_LAYERS  = 7;
    localparam int DILI_LAYERS   = 8;
    localparam int Q_KYBER       = 3329;
    localparam int Q_DILITHIUM   = 8380417;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [2:0] top_layer(input logic kyber);
        return kyber ? 3'(KYBER_LAYERS - 1) : 3'(DILI_LAYERS - 1);
    endfunction

endpackage

// File: rtl/ntt_ctrl_if.sv
// Host-side request and memory-side strobe bundle of the NTT controller.
// The controller takes the slave view; the requester takes the master view.
interface ntt_ctrl_if;

    logic       start_i;
    logic       mode_i;
    logic       sel_red_i;
    logic       busy_o;
    logic       done_o;
    logic       rd_en_o;
    logic [7:0] rd_addr_a_o;
    logic [7:0] rd_addr_b_o;
    logic [7:0] twiddle_addr_o;
    logic       wr_en_o;
    logic [7:0] wr_addr_a_o;
    logic [7:0] wr_addr_b_o;
    logic       sel_butterfly_o;
    logic       sel_red_o;

    modport master (
        output start_i, mode_i, sel_red_i,
        input  busy_o, done_o, rd_en_o,
        input  rd_addr_a_o, rd_addr_b_o, twiddle_addr_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o,
        input  sel_butterfly_o, sel_red_o
    );

    modport slave (
        input  start_i, mode_i, sel_red_i,
        output busy_o, done_o, rd_en_o,
        output rd_addr_a_o, rd_addr_b_o, twiddle_addr_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o,
        output sel_butterfly_o, sel_red_o
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly pair and twiddle index for layer l, pair p:
// len = 128>>l, blk = p>>(7-l), a = blk<<(8-l) | (p & (len-1)).
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [2:0] layer,
    input  logic [6:0] pair,
    input  logic       mode,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [7:0] twiddle
);

    logic [7:0] len;
    logic [7:0] blk;
    logic [7:0] off;
    logic [7:0] base;
    logic [3:0] sh_blk;
    logic [3:0] sh_base;
    logic [8:0] tw_inv;

    assign sh_blk  = 4'd7 - {1'b0, layer};
    assign sh_base = 4'd8 - {1'b0, layer};
    assign len     = 8'd128 >> layer;
    assign blk     = {1'b0, pair} >> sh_blk;
    assign off     = {1'b0, pair} & (len - 8'd1);
    assign base    = blk << sh_base;
    assign addr_a  = base | off;
    assign addr_b  = addr_a + len;

    // Inverse walks the twiddle table of each layer backwards.
    assign tw_inv  = (9'd1 << ({1'b0, layer} + 4'd1)) - 9'd1 - {1'b0, blk};
    assign twiddle = mode ? tw_inv[7:0] : (8'd1 << layer) + blk;

endmodule

// File: rtl/ntt_ctrl.sv
// NTT layer/pair sequencer: issues butterfly reads and twiddle indices,
// then the matching writes one cycle later.
module ntt_ctrl
    import ntt_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    ntt_ctrl_if.slave bus
);

    state_t     state, state_n;
    logic [2:0] layer, layer_n;
    logic [6:0] pair, pair_n;
    logic       mode, mode_n;
    logic       red, red_n;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] wr_a;
    logic [7:0] wr_b;
    logic       busy;
    logic       done;
    logic [7:0] gen_a;
    logic [7:0] gen_b;
    logic [7:0] gen_tw;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
    logic [2:0] last;

    ntt_addr_gen u_addr (
        .layer   (layer),
        .pair    (pair),
        .mode    (mode),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .twiddle (gen_tw)
    );

    assign last = mode ? 3'd0 : top_layer(red);

    always_comb begin
        state_n = state;
        layer_n = layer;
        pair_n  = pair;
        mode_n  = mode;
        red_n   = red;
        unique case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_n = RUN;
                    mode_n  = bus.mode_i;
                    red_n   = bus.sel_red_i;
                    pair_n  = 7'd0;
                    layer_n = bus.mode_i ? top_layer(bus.sel_red_i) : 3'd0;
                end
            end
            RUN: begin
                pair_n = pair + 7'd1;
                if (pair == 7'd127) state_n = DRAIN;
            end
            DRAIN: begin
                if (layer == last) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                    pair_n  = 7'd0;
                    layer_n = mode ? layer - 3'd1 : layer + 3'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up
    // with the counters they qualify.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            layer <= 3'd0;
            pair  <= 7'd0;
            mode  <= 1'b0;
            red   <= 1'b0;
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            wr_a  <= 8'd0;
            wr_b  <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            layer <= layer_n;
            pair  <= pair_n;
            mode  <= mode_n;
            red   <= red_n;
            rd_en <= (state_n == RUN);
            wr_en <= rd_en;
            wr_a  <= rd_a;
            wr_b  <= rd_b;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
        end
    end

    assign rd_a = rd_en ? gen_a : 8'd0;
    assign rd_b = rd_en ? gen_b : 8'd0;

    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
    assign bus.rd_en_o         = rd_en;
    assign bus.rd_addr_a_o     = rd_a;
    assign bus.rd_addr_b_o     = rd_b;
    assign bus.twiddle_addr_o  = rd_en ? gen_tw : 8'd0;
    assign bus.wr_en_o         = wr_en;
    assign bus.wr_addr_a_o     = wr_a;
    assign bus.wr_addr_b_o     = wr_b;
    assign bus.sel_butterfly_o = busy & mode;
    assign bus.sel_red_o       = busy & red;

endmodule
